// File: rtl/dog_pkg.sv
// Shared types and defaults for the DoG extrema detector.
package dog_pkg;
  localparam int DOG_DW    = 9;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef logic signed [DOG_DW-1:0] dog_px_t;
  // 3x3 window, index r*3+c: r=0 oldest line, c=2 newest column
  typedef dog_px_t [8:0] win3x3_t;
endpackage

// File: rtl/dog_extrema_detector_if.sv
// Pixel-in / keypoint-out bundle of the extrema detector.
interface dog_extrema_detector_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  import dog_pkg::*;

  logic          ivalid;
  logic          isof;
  dog_px_t       DOGImageData1;
  dog_px_t       DOGImageData2;
  dog_px_t       DOGImageData3;
  logic          ovalid;
  logic          okey;
  logic          omax;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;

  modport master (
    output ivalid, isof, DOGImageData1, DOGImageData2, DOGImageData3,
    input  ovalid, okey, omax, ox, oy
  );

  modport slave (
    input  ivalid, isof, DOGImageData1, DOGImageData2, DOGImageData3,
    output ovalid, okey, omax, ox, oy
  );
endinterface

// File: rtl/dog_line_window.sv
// One DoG stream: two line delays feeding a 3x3 shift window, advanced per accepted pixel.
module dog_line_window
  import dog_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  dog_px_t din,
  output win3x3_t win
);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  dog_px_t        line1 [IMG_W];
  dog_px_t        line2 [IMG_W];
  logic [AW-1:0]  ptr;
  dog_px_t        tap1;
  dog_px_t        tap2;

  // read-before-write at the same slot gives exactly IMG_W pixels of delay
  assign tap1 = line1[ptr];
  assign tap2 = line2[ptr];

  always_ff @(posedge clk) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= (ptr == AW'(IMG_W-1)) ? '0 : ptr + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      line1[ptr] <= din;
      line2[ptr] <= tap1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int r = 0; r < 3; r++) begin
        win[r*3+0] <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2] <= tap2;
      win[5] <= tap1;
      win[8] <= din;
    end
  end
endmodule

// File: rtl/dog_extrema_detector.sv
// 3x3x3 strict-extremum detector on DoG scale 2 with contrast threshold; 2-stage pipeline.
module dog_extrema_detector
  import dog_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int CONTRAST_TH = 4,
  parameter int XW          = 10,
  parameter int YW          = 9
) (
  input  logic                   iclk,
  input  logic                   irst,
  dog_extrema_detector_if.slave  bus
);
  localparam int      STAGES = 2;
  localparam dog_px_t TH_P   = dog_px_t'(CONTRAST_TH);
  localparam dog_px_t TH_N   = dog_px_t'(-CONTRAST_TH);

  dog_px_t [2:0] px;
  win3x3_t [2:0] win;

  assign px[0] = bus.DOGImageData1;
  assign px[1] = bus.DOGImageData2;
  assign px[2] = bus.DOGImageData3;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_lane
      dog_line_window #(.IMG_W(IMG_W)) u_win (
        .clk (iclk),
        .rst (irst),
        .en  (bus.ivalid),
        .din (px[k]),
        .win (win[k])
      );
    end
  endgenerate

  // raster counters; isof with ivalid relabels the current pixel as (0,0)
  logic [XW-1:0] x_cnt, cur_x;
  logic [YW-1:0] y_cnt, cur_y;
  logic          sof;

  always_comb begin
    sof   = bus.ivalid & bus.isof;
    cur_x = sof ? '0 : x_cnt;
    cur_y = sof ? '0 : y_cnt;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (bus.ivalid) begin
      if (cur_x == XW'(IMG_W-1)) begin
        x_cnt <= '0;
        y_cnt <= (cur_y == YW'(IMG_H-1)) ? '0 : cur_y + YW'(1);
      end else begin
        x_cnt <= cur_x + XW'(1);
        y_cnt <= cur_y;
      end
    end
  end

  logic [STAGES:0] vld_pipe;
  logic [XW-1:0]   x0, x1;
  logic [YW-1:0]   y0, y1;
  logic            elig0, elig1;

  // stage 0 lines the centre coordinates up with the freshly shifted window
  always_ff @(posedge iclk) begin
    if (irst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[STAGES-1:0], bus.ivalid};
  end

  always_ff @(posedge iclk) begin
    if (bus.ivalid) begin
      x0    <= cur_x - XW'(1);
      y0    <= cur_y - YW'(1);
      elig0 <= (cur_x >= XW'(2)) && (cur_y >= YW'(2));
    end
  end

  dog_px_t     ctr;
  logic [25:0] gt, lt;
  logic        cmax, cmin;

  assign ctr = win[1][4];

  always_comb begin
    gt = '0;
    lt = '0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 9; i++)
        if (!(s == 1 && i == 4)) begin
          gt[(s*9+i > 13) ? s*9+i-1 : s*9+i] = $signed(ctr) > $signed(win[s][i]);
          lt[(s*9+i > 13) ? s*9+i-1 : s*9+i] = $signed(ctr) < $signed(win[s][i]);
        end
    cmax = $signed(ctr) > $signed(TH_P);
    cmin = $signed(ctr) < $signed(TH_N);
  end

  logic [25:0] gt1, lt1;
  logic        cmax1, cmin1;

  always_ff @(posedge iclk) begin
    gt1   <= gt;
    lt1   <= lt;
    cmax1 <= cmax;
    cmin1 <= cmin;
    x1    <= x0;
    y1    <= y0;
    elig1 <= elig0;
  end

  logic          okey, omax;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic          is_max, is_min;

  assign is_max = (&gt1) & cmax1;
  assign is_min = (&lt1) & cmin1;

  always_ff @(posedge iclk) begin
    if (irst) begin
      okey <= 1'b0;
      omax <= 1'b0;
      ox   <= '0;
      oy   <= '0;
    end else begin
      okey <= vld_pipe[1] & elig1 & (is_max | is_min);
      omax <= vld_pipe[1] & elig1 & is_max;
      if (vld_pipe[1]) begin
        ox <= x1;
        oy <= y1;
      end
    end
  end

  assign bus.ovalid = vld_pipe[STAGES];
  assign bus.okey   = okey;
  assign bus.omax   = omax;
  assign bus.ox     = ox;
  assign bus.oy     = oy;
endmodule

// File: tb/tb_dog_extrema_detector.sv
// Scoreboard bench: a 3x3x3 reference model predicts every output pixel of an 8x6 image.
module tb_dog_extrema_detector;
  import dog_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int TH = 4;

  typedef struct packed {
    logic       key;
    logic       mx;
    logic       chk;
    logic [9:0] x;
    logic [8:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dog_extrema_detector_if #(.XW(10), .YW(9)) bus ();

  dog_extrema_detector #(
    .IMG_W(W), .IMG_H(H), .CONTRAST_TH(TH), .XW(10), .YW(9)
  ) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc_cnt, ov_cnt, key_cnt;
  int   tx, ty;
  int   img1 [H][W];
  int   img2 [H][W];
  int   img3 [H][W];
  int   f1 [H][W];
  int   f2 [H][W];
  int   f3 [H][W];
  exp_t sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference: strict extremum over 26 neighbours plus contrast
  task automatic model(input int x, input int y, output logic key, output logic mx);
    int  c, v;
    bit  all_gt, all_lt;
    key = 1'b0;
    mx  = 1'b0;
    if (x >= 2 && y >= 2) begin
      c = img2[y-1][x-1];
      all_gt = 1'b1;
      all_lt = 1'b1;
      for (int s = 0; s < 3; s++)
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            if (!(s == 1 && dy == 1 && dx == 1)) begin
              v = (s == 0) ? img1[y-2+dy][x-2+dx] :
                  (s == 1) ? img2[y-2+dy][x-2+dx] : img3[y-2+dy][x-2+dx];
              if (!(c > v)) all_gt = 1'b0;
              if (!(c < v)) all_lt = 1'b0;
            end
      mx  = all_gt && (c > TH);
      key = mx || (all_lt && (c < -TH));
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.ivalid        = 1'b0;
    bus.isof          = 1'($urandom_range(0, 1));
    bus.DOGImageData1 = 9'($urandom);
    bus.DOGImageData2 = 9'($urandom);
    bus.DOGImageData3 = 9'($urandom);
  endtask

  task automatic drive_px(input int a, input int b, input int c, input bit sof, input int gap);
    exp_t e;
    logic k, m;
    repeat (gap) idle();
    @(posedge clk); #1;
    bus.ivalid        = 1'b1;
    bus.isof          = sof;
    bus.DOGImageData1 = 9'(a);
    bus.DOGImageData2 = 9'(b);
    bus.DOGImageData3 = 9'(c);
    if (sof) begin tx = 0; ty = 0; end
    img1[ty][tx] = a;
    img2[ty][tx] = b;
    img3[ty][tx] = c;
    model(tx, ty, k, m);
    e.key = k;
    e.mx  = m;
    e.chk = (tx >= 1 && ty >= 1);
    e.x   = 10'(tx - 1);
    e.y   = 9'(ty - 1);
    sb.push_back(e);
    acc_cnt++;
    tx++;
    if (tx == W) begin
      tx = 0;
      ty = (ty == H - 1) ? 0 : ty + 1;
    end
  endtask

  task automatic clear_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        f1[y][x] = 0; f2[y][x] = 0; f3[y][x] = 0;
      end
  endtask

  task automatic rand_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        f1[y][x] = int'($urandom_range(0, 120)) - 60;
        f2[y][x] = int'($urandom_range(0, 120)) - 60;
        f3[y][x] = int'($urandom_range(0, 120)) - 60;
      end
  endtask

  task automatic send_frame(input bit sof, input bit gaps, input int npx);
    for (int p = 0; p < npx; p++)
      drive_px(f1[p/W][p%W], f2[p/W][p%W], f3[p/W][p%W], sof && p == 0,
               gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic run_frame(input string tag, input bit sof, input bit gaps, input int exp_keys);
    acc_cnt = 0; ov_cnt = 0; key_cnt = 0;
    send_frame(sof, gaps, W * H);
    repeat (5) idle();
    chk({tag, "_ovalid_cnt"}, ov_cnt, acc_cnt);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    if (exp_keys >= 0) chk({tag, "_key_cnt"}, key_cnt, exp_keys);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ovalid) begin
      ov_cnt++;
      if (bus.okey) key_cnt++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("okey", 32'(bus.okey), 32'(e.key));
        chk("omax", 32'(bus.omax), 32'(e.mx));
        if (e.chk) begin
          chk("ox", 32'(bus.ox), 32'(e.x));
          chk("oy", 32'(bus.oy), 32'(e.y));
        end
      end
    end else begin
      chk("idle_okey_omax", 32'({bus.okey, bus.omax}), 32'd0);
    end
  end

  initial begin
    bus.ivalid = 1'b0; bus.isof = 1'b0;
    bus.DOGImageData1 = '0; bus.DOGImageData2 = '0; bus.DOGImageData3 = '0;
    tx = 0; ty = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovalid", 32'(bus.ovalid), 0);
    chk("rst_okey",   32'(bus.okey), 0);
    chk("rst_omax",   32'(bus.omax), 0);
    chk("rst_ox",     32'(bus.ox), 0);
    chk("rst_oy",     32'(bus.oy), 0);
    rst = 1'b0;

    clear_frame();
    run_frame("zero", 1'b1, 1'b0, 0);

    // counters wrapped from the previous frame, no isof needed
    clear_frame(); f2[2][3] = 50;
    run_frame("max50", 1'b0, 1'b0, 1);
    clear_frame(); f2[2][3] = -50;
    run_frame("min50", 1'b1, 1'b0, 1);
    clear_frame(); f2[2][3] = 4;
    run_frame("th4", 1'b1, 1'b0, 0);
    clear_frame(); f2[2][3] = 5;
    run_frame("th5", 1'b1, 1'b0, 1);
    clear_frame(); f2[2][3] = -4;
    run_frame("thm4", 1'b1, 1'b0, 0);
    clear_frame(); f2[2][3] = 50; f1[1][2] = 50;
    run_frame("tie", 1'b1, 1'b0, 0);
    clear_frame(); f2[2][0] = 50;
    run_frame("left", 1'b1, 1'b0, 0);
    clear_frame(); f2[2][7] = 50;
    run_frame("right", 1'b1, 1'b0, 0);
    clear_frame(); f2[0][3] = 50;
    run_frame("top", 1'b1, 1'b0, 0);

    // partial random frame, then isof restarts mid-frame
    rand_frame();
    acc_cnt = 0;
    send_frame(1'b1, 1'b0, 20);
    repeat (5) idle();
    clear_frame(); f2[2][3] = 50;
    run_frame("midsof", 1'b1, 1'b0, 1);

    run_frame("gaps", 1'b1, 1'b1, 1);
    rand_frame();
    run_frame("rand", 1'b1, 1'b1, -1);

    // reset right after pixel (5,3); results of (4,3),(5,3) are dropped
    clear_frame(); f2[2][3] = 50;
    send_frame(1'b1, 1'b0, 3 * W + 6);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ivalid = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    chk("midrst_ovalid", 32'(bus.ovalid), 0);
    chk("midrst_okey",   32'(bus.okey), 0);
    chk("midrst_ox",     32'(bus.ox), 0);
    chk("midrst_oy",     32'(bus.oy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tx = 0; ty = 0;
    run_frame("postrst", 1'b1, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
